instr_fetch_unit: RTL and testbench

//  Fetch stage upstream of immediate sign-extension/decode. Holds the PC and requests

---
 rtl/riscv_pkg.sv | 18 +
 rtl/instr_fetch_unit_if.sv | 34 +++
 rtl/instr_fetch_unit_pc_next_gen.sv | 22 ++
 rtl/instr_fetch_unit.sv | 97 +++++++++
 tb/tb_instr_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch stage.
package riscv_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   localparam int unsigned DEFAULT_ADDR_WIDTH = 32;

   // addi x0, x0, 0: presented to decode while no real instruction is held
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory and decode handshake bundle for the fetch stage.
interface instr_fetch_unit_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
);

   // instruction memory side
   logic                  IMemReq;
   logic [ADDR_WIDTH-1:0] IMemAddr;
   logic                  IMemAck;
   logic [DATA_WIDTH-1:0] IMemData;

   // decode side
   logic [DATA_WIDTH-1:0] Instr;
   logic [ADDR_WIDTH-1:0] PC;
   logic                  InstrValid;
   logic                  InstrReady;
   logic                  PCSrc;
   logic [DATA_WIDTH-1:0] ImmOp;
   logic                  MisalignErr;

   // fetch unit
   modport master (
      output IMemReq, IMemAddr, Instr, PC, InstrValid, MisalignErr,
      input  IMemAck, IMemData, InstrReady, PCSrc, ImmOp
   );

   // memory + decode environment
   modport slave (
      input  IMemReq, IMemAddr, Instr, PC, InstrValid, MisalignErr,
      output IMemAck, IMemData, InstrReady, PCSrc, ImmOp
   );

endinterface

// File: rtl/instr_fetch_unit_pc_next_gen.sv
// Next-PC selection (sequential or branch target) with word-alignment check.
module pc_next_gen #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] PC,
   input  logic [DATA_WIDTH-1:0] ImmOp,
   input  logic                  PCSrc,
   output logic [ADDR_WIDTH-1:0] NextPC,
   output logic                  Misalign
);

   // adds wrap modulo 2^ADDR_WIDTH; negative offsets work as two's complement
   always_comb begin
      NextPC   = PC + ADDR_WIDTH'(4);
      if (PCSrc) begin
         NextPC = PC + ImmOp[ADDR_WIDTH-1:0];
      end
      Misalign = (NextPC[1:0] != 2'b00);
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, requests instructions from memory and hands them to decode.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned           ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   instr_fetch_unit_if.master     bus
);

   fetch_state_t          state_q,     state_d;
   logic [ADDR_WIDTH-1:0] fetch_pc_q,  fetch_pc_d;
   logic [ADDR_WIDTH-1:0] pc_q,        pc_d;
   logic [DATA_WIDTH-1:0] instr_q,     instr_d;
   logic                  misalign_q,  misalign_d;

   logic [ADDR_WIDTH-1:0] next_pc;
   logic                  next_misalign;

   pc_next_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_pc_next_gen (
      .PC       (pc_q),
      .ImmOp    (bus.ImmOp),
      .PCSrc    (bus.PCSrc),
      .NextPC   (next_pc),
      .Misalign (next_misalign)
   );

   // next-state and datapath update; branch inputs only matter in the accept cycle
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      misalign_d = misalign_q;
      case (state_q)
         BOOT: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (bus.IMemAck) begin
               instr_d = bus.IMemData;
               pc_d    = fetch_pc_q;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (bus.InstrReady) begin
               if (next_misalign) begin
                  misalign_d = 1'b1;
                  state_d    = HALT;
               end else begin
                  fetch_pc_d = next_pc;
                  state_d    = FETCH;
               end
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // state and datapath registers, async active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         fetch_pc_q <= RESET_PC;
         pc_q       <= RESET_PC;
         instr_q    <= DATA_WIDTH'(NOP_INSTR);
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         misalign_q <= misalign_d;
      end
   end

   // request/valid decode straight from the state register, so reset drops them at once
   assign bus.IMemReq     = (state_q == FETCH);
   assign bus.IMemAddr    = fetch_pc_q;
   assign bus.InstrValid  = (state_q == HOLD);
   assign bus.Instr       = instr_q;
   assign bus.PC          = pc_q;
   assign bus.MisalignErr = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed sequences, a branch vector table,
// and a randomized run checked against a handshake-level reference model.
module tb_instr_fetch_unit;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   instr_fetch_unit #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] from_pc;
      logic        pcsrc;
      logic [31:0] imm;
      logic [31:0] exp_next;
      logic        exp_mis;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.IMemAck    = 1'b0;
      bus.IMemData   = $urandom;
      bus.InstrReady = 1'b0;
      bus.PCSrc      = 1'b0;
      bus.ImmOp      = '0;
   endtask

   // leaves the bench in the first cycle after release
   task automatic do_reset();
      rst_n = 1'b0;
      drive_idle();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // bounded wait for IMemReq (which=0) or InstrValid (which=1)
   task automatic wait_sig(input int which, input string name);
      logic s;
      for (int n = 0; n < 20; n++) begin
         s = (which == 0) ? bus.IMemReq : bus.InstrValid;
         if (s) break;
         tick();
      end
      s = (which == 0) ? bus.IMemReq : bus.InstrValid;
      chk(name, {31'b0, s}, 32'd1);
   endtask

   // reference-model state for the random run
   logic [31:0] m_addr, m_pend_pc, m_pend_instr, m_next;
   logic        m_halt, m_req, m_valid, m_boot;
   int          halt_cycles;
   logic        a_ack, a_ready, a_src;
   logic [31:0] a_imm;

   initial begin
      vecs[0] = '{32'h0000_0010, 1'b1, 32'hFFFF_FFF8, 32'h0000_0008, 1'b0};
      vecs[1] = '{32'h0000_0010, 1'b1, 32'h0000_0100, 32'h0000_0110, 1'b0};
      vecs[2] = '{32'h0000_0010, 1'b0, 32'h0000_0100, 32'h0000_0014, 1'b0};
      vecs[3] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[4] = '{32'h0000_0020, 1'b1, 32'h0000_0006, 32'h0000_0000, 1'b1};
      vecs[5] = '{32'h0000_0040, 1'b1, 32'hFFFF_FFC0, 32'h0000_0000, 1'b0};

      drive_idle();
      // reset state while rst_n held low
      tick();
      chk("rst_req",    {31'b0, bus.IMemReq},     32'd0);
      chk("rst_valid",  {31'b0, bus.InstrValid},  32'd0);
      chk("rst_instr",  bus.Instr,                32'h0000_0013);
      chk("rst_pc",     bus.PC,                   32'h0000_0000);
      chk("rst_addr",   bus.IMemAddr,             32'h0000_0000);
      chk("rst_mis",    {31'b0, bus.MisalignErr}, 32'd0);

      // ---- 1: ack tied high, decode always ready
      do_reset();
      chk("boot_req", {31'b0, bus.IMemReq}, 32'd0);
      bus.IMemAck    = 1'b1;
      bus.IMemData   = 32'h0050_0093;
      bus.InstrReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t1_req",   {31'b0, bus.IMemReq},    32'd1);
         chk("t1_addr",  bus.IMemAddr,            32'(4 * i));
         chk("t1_nval",  {31'b0, bus.InstrValid}, 32'd0);
         tick();
         chk("t1_valid", {31'b0, bus.InstrValid}, 32'd1);
         chk("t1_pc",    bus.PC,                  32'(4 * i));
         chk("t1_instr", bus.Instr,               32'h0050_0093);
         chk("t1_noreq", {31'b0, bus.IMemReq},    32'd0);
      end

      // ---- 2: ack delayed 3 cycles
      do_reset();
      bus.InstrReady = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("t2_req",  {31'b0, bus.IMemReq},    32'd1);
         chk("t2_addr", bus.IMemAddr,            32'h0);
         chk("t2_nval", {31'b0, bus.InstrValid}, 32'd0);
         tick();
      end
      chk("t2_req_ack", {31'b0, bus.IMemReq}, 32'd1);
      bus.IMemAck    = 1'b1;
      bus.IMemData   = 32'hCAFE_0013;
      bus.InstrReady = 1'b0;
      tick();
      bus.IMemAck  = 1'b0;
      bus.IMemData = 32'h1111_1111;
      chk("t2_valid", {31'b0, bus.InstrValid}, 32'd1);
      chk("t2_instr", bus.Instr,               32'hCAFE_0013);

      // ---- 3: decode stalls 5 cycles; stray acks must be ignored
      for (int i = 0; i < 5; i++) begin
         bus.IMemAck = (i % 2 == 0);
         chk("t3_valid", {31'b0, bus.InstrValid}, 32'd1);
         chk("t3_pc",    bus.PC,                  32'h0);
         chk("t3_instr", bus.Instr,               32'hCAFE_0013);
         chk("t3_noreq", {31'b0, bus.IMemReq},    32'd0);
         tick();
      end
      bus.IMemAck    = 1'b0;
      bus.InstrReady = 1'b1;
      bus.PCSrc      = 1'b0;
      bus.ImmOp      = 32'h0000_0100;
      tick();
      bus.InstrReady = 1'b0;
      chk("t3_next_req",  {31'b0, bus.IMemReq}, 32'd1);
      chk("t3_next_addr", bus.IMemAddr,         32'h4);

      // ---- reset mid-FETCH with an ack coincident with rst_n low
      bus.IMemAck  = 1'b1;
      bus.IMemData = 32'hDEAD_BEEF;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", {31'b0, bus.IMemReq}, 32'd0);
      tick();
      chk("mid_rst_instr", bus.Instr,               32'h0000_0013);
      chk("mid_rst_pc",    bus.PC,                  32'h0);
      chk("mid_rst_valid", {31'b0, bus.InstrValid}, 32'd0);
      bus.IMemAck = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("refetch_req",  {31'b0, bus.IMemReq}, 32'd1);
      chk("refetch_addr", bus.IMemAddr,         32'h0);

      // ---- branch vector table
      foreach (vecs[v]) begin
         do_reset();
         wait_sig(0, "vec_boot_req");
         bus.IMemAck  = 1'b1;
         bus.IMemData = memword(32'h0);
         tick();
         bus.IMemAck    = 1'b0;
         bus.InstrReady = 1'b1;
         bus.PCSrc      = 1'b1;
         bus.ImmOp      = vecs[v].from_pc;
         tick();
         bus.InstrReady = 1'b0;
         chk("vec_setup_addr", bus.IMemAddr, vecs[v].from_pc);
         bus.IMemAck  = 1'b1;
         bus.IMemData = memword(vecs[v].from_pc);
         tick();
         bus.IMemAck = 1'b0;
         chk("vec_pc",    bus.PC,    vecs[v].from_pc);
         chk("vec_instr", bus.Instr, memword(vecs[v].from_pc));
         bus.InstrReady = 1'b1;
         bus.PCSrc      = vecs[v].pcsrc;
         bus.ImmOp      = vecs[v].imm;
         tick();
         drive_idle();
         if (vecs[v].exp_mis) begin
            for (int k = 0; k < 4; k++) begin
               chk("vec_halt_mis",   {31'b0, bus.MisalignErr}, 32'd1);
               chk("vec_halt_req",   {31'b0, bus.IMemReq},     32'd0);
               chk("vec_halt_valid", {31'b0, bus.InstrValid},  32'd0);
               bus.IMemAck = 1'b1;
               tick();
            end
            bus.IMemAck = 1'b0;
         end else begin
            chk("vec_mis",  {31'b0, bus.MisalignErr}, 32'd0);
            chk("vec_req",  {31'b0, bus.IMemReq},     32'd1);
            chk("vec_next", bus.IMemAddr,             vecs[v].exp_next);
         end
      end

      // ---- randomized run against the handshake model
      do_reset();
      m_addr = 32'h0; m_halt = 1'b0; m_boot = 1'b1;
      m_req = 1'b0; m_valid = 1'b0;
      m_pend_pc = 32'h0; m_pend_instr = 32'h0000_0013;
      halt_cycles = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         // compare
         if (m_halt) begin
            chk("r_halt_req",   {31'b0, bus.IMemReq},     32'd0);
            chk("r_halt_valid", {31'b0, bus.InstrValid},  32'd0);
            chk("r_halt_mis",   {31'b0, bus.MisalignErr}, 32'd1);
         end else begin
            chk("r_mis",   {31'b0, bus.MisalignErr}, 32'd0);
            chk("r_req",   {31'b0, bus.IMemReq},     {31'b0, m_req});
            chk("r_valid", {31'b0, bus.InstrValid},  {31'b0, m_valid});
            if (m_req)   chk("r_addr",  bus.IMemAddr, m_addr);
            if (m_valid) begin
               chk("r_pc",    bus.PC,    m_pend_pc);
               chk("r_instr", bus.Instr, m_pend_instr);
            end
         end

         // choose stimulus
         a_ack   = ($urandom_range(0, 2) == 0);
         a_ready = ($urandom_range(0, 1) == 0);
         a_src   = ($urandom_range(0, 1) == 0);
         a_imm   = 32'($urandom_range(0, 63) * 4) - 32'd128;
         if ($urandom_range(0, 15) == 0) a_imm = a_imm + 32'($urandom_range(1, 3));
         bus.IMemAck    = a_ack;
         bus.IMemData   = (a_ack && m_req) ? memword(m_addr) : $urandom;
         bus.InstrReady = a_ready;
         bus.PCSrc      = a_src;
         bus.ImmOp      = a_imm;

         // advance the model one cycle
         if (m_halt) begin
            halt_cycles++;
            if (halt_cycles > 4) begin
               do_reset();
               m_addr = 32'h0; m_halt = 1'b0; m_boot = 1'b1;
               m_req = 1'b0; m_valid = 1'b0;
               m_pend_pc = 32'h0; m_pend_instr = 32'h0000_0013;
               halt_cycles = 0;
               continue;
            end
         end else if (m_boot) begin
            m_boot = 1'b0;
            m_req  = 1'b1;
         end else if (m_req) begin
            if (a_ack) begin
               m_pend_pc    = m_addr;
               m_pend_instr = memword(m_addr);
               m_req        = 1'b0;
               m_valid      = 1'b1;
            end
         end else if (m_valid && a_ready) begin
            m_next  = a_src ? (m_pend_pc + a_imm) : (m_pend_pc + 32'd4);
            m_valid = 1'b0;
            if (m_next % 4 != 0) begin
               m_halt = 1'b1;
            end else begin
               m_addr = m_next;
               m_req  = 1'b1;
            end
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
